// File: rtl/caesar_decipher_stream.sv
// Streaming Caesar decipher with output FIFO; CAESAR_DIGIT_ROT_EN also rotates '0'..'9' by k mod 10.
// Latency: byte accepted at edge N is presented after edge N (1 cycle minimum).
// Backpressure: in_ready registered, low when FIFO full, in NOKEY, or while a finished message drains.
module caesar_decipher_stream #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_load,
  input  logic [4:0]      key_in,
  output logic            key_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_ct,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_pt,
  output logic            out_last,
  output logic [CNTW-1:0] msg_count,
  output logic            key_set
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     PTR_ONE  = (AW+1)'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  typedef enum logic [1:0] {S_NOKEY, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  logic [8:0]      r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [4:0]      r_key;
  logic            r_key_set;
  logic            r_key_err;
  logic            r_in_rdy;
  logic [7:0]      r_hold_pt;
  logic            r_hold_last;
  logic [CNTW-1:0] r_msg_cnt;

  state_t          w_state_nxt;
  logic [AW:0]     w_cnt;
  logic [AW:0]     w_cnt_nxt;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [8:0]      w_head;
  logic            w_key_acc;
  logic            w_key_rej;
  logic [4:0]      w_key_red;
  logic [7:0]      w_pt;

  function automatic logic [7:0] decipher(input logic [7:0] c, input logic [4:0] k);
    logic [5:0] d;
    logic [3:0] km;
    d  = '0;
    km = '0;
    decipher = c;
    if (c >= 8'h41 && c <= 8'h5A) begin
      d = 6'(c - 8'h41) + 6'd26 - {1'b0, k};
      if (d >= 6'd26) d = d - 6'd26;
      decipher = 8'h41 + {2'b00, d};
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      d = 6'(c - 8'h61) + 6'd26 - {1'b0, k};
      if (d >= 6'd26) d = d - 6'd26;
      decipher = 8'h61 + {2'b00, d};
    end
`ifdef CAESAR_DIGIT_ROT_EN
    else if (c >= 8'h30 && c <= 8'h39) begin
      // k is already 0..25, so two conditional subtracts give k mod 10
      if (k >= 5'd20)      km = 4'(k - 5'd20);
      else if (k >= 5'd10) km = 4'(k - 5'd10);
      else                 km = k[3:0];
      d = 6'(c - 8'h30) + 6'd10 - {2'b00, km};
      if (d >= 6'd10) d = d - 6'd10;
      decipher = 8'h30 + {2'b00, d};
    end
`endif
  endfunction

  assign w_cnt     = r_wptr - r_rptr;
  assign w_empty   = (w_cnt == '0);
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign w_push    = in_valid & r_in_rdy;
  assign w_pop     = ~w_empty & out_ready;
  assign w_cnt_nxt = w_cnt + (w_push ? PTR_ONE : '0) - (w_pop ? PTR_ONE : '0);
  assign w_key_red = (key_in >= 5'd26) ? key_in - 5'd26 : key_in;
  assign w_pt      = decipher(in_ct, r_key);

  always_comb begin
    w_state_nxt = r_state;
    w_key_acc   = 1'b0;
    w_key_rej   = 1'b0;
    case (r_state)
      S_NOKEY: begin
        if (key_load) begin
          w_key_acc   = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (key_load) begin
          if (w_empty && !w_push) w_key_acc = 1'b1;
          else                    w_key_rej = 1'b1;
        end
        if (w_push && in_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_key_rej = key_load;
        if (w_pop && w_cnt == PTR_ONE) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_NOKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {in_last, w_pt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_NOKEY;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_key       <= '0;
      r_key_set   <= 1'b0;
      r_key_err   <= 1'b0;
      r_in_rdy    <= 1'b0;
      r_hold_pt   <= '0;
      r_hold_last <= 1'b0;
      r_msg_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_key_err <= w_key_rej;
      // full check uses next occupancy so a same-cycle pop never frees a slot early
      r_in_rdy  <= (w_state_nxt == S_RUN) && (w_cnt_nxt != FULL_CNT);
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) begin
        r_rptr      <= r_rptr + PTR_ONE;
        r_hold_pt   <= w_head[7:0];
        r_hold_last <= w_head[8];
        if (w_head[8]) r_msg_cnt <= r_msg_cnt + CNT_ONE;
      end
      if (w_key_acc) begin
        r_key     <= w_key_red;
        r_key_set <= 1'b1;
      end
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = ~w_empty;
  assign out_pt    = w_empty ? r_hold_pt : w_head[7:0];
  assign out_last  = w_empty ? r_hold_last : w_head[8];
  assign key_err   = r_key_err;
  assign key_set   = r_key_set;
  assign msg_count = r_msg_cnt;

endmodule

// File: tb/tb_caesar_decipher_stream.sv
// Directed bench for caesar_decipher_stream; expected bytes are hand-deciphered.
module tb_caesar_decipher_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [4:0]  key_in = '0;
  logic        key_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_ct = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pt;
  logic        out_last;
  logic [15:0] msg_count;
  logic        key_set;

  int n_chk  = 0;
  int n_pass = 0;

  caesar_decipher_stream #(.DEPTH(4), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_err(key_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_ct(in_ct), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_pt(out_pt), .out_last(out_last),
    .msg_count(msg_count), .key_set(key_set)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_key(input logic [4:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  initial begin
    string s_ct, s_pt;
    logic [7:0] exp_dig;
    int sent, rcv;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pt", out_pt, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_key_set", key_set, 0);
    chk("rst_msg_count", msg_count, 0);
    rst = 1'b0;

    // no key yet: input must stay blocked
    in_valid = 1'b1; in_ct = "k";
    tick(); tick();
    chk("nokey_in_ready", in_ready, 0);
    chk("nokey_out_valid", out_valid, 0);
    in_valid = 1'b0;

    // key 3, "khoor" -> "hello"
    load_key(5'd3);
    chk("t1_key_set", key_set, 1);
    chk("t1_key_err", key_err, 0);
    chk("t1_in_ready", in_ready, 1);
    out_ready = 1'b1;
    s_ct = "khoor"; s_pt = "hello";
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_ct = s_ct[i]; in_last = (i == 4);
      chk("t1_rdy", in_ready, 1);
      tick();
      chk("t1_vld", out_valid, 1);
      chk("t1_pt", out_pt, s_pt[i]);
      chk("t1_last", out_last, (i == 4) ? 1 : 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_drain_rdy", in_ready, 0);
    tick();
    chk("t1_msg_count", msg_count, 1);
    chk("t1_empty", out_valid, 0);
    chk("t1_hold_pt", out_pt, "o");
    chk("t1_hold_last", out_last, 1);
    chk("t1_rdy_back", in_ready, 1);

    // key_in 29 reduces to 3
    load_key(5'd29);
    chk("t2_key_err", key_err, 0);
`ifdef CAESAR_DIGIT_ROT_EN
    exp_dig = "9";
`else
    exp_dig = "2";
`endif
    s_ct = "Ac2"; s_pt = "Xz?";
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ct = s_ct[i];
      tick();
      chk("t2_pt", out_pt, (i == 2) ? exp_dig : s_pt[i]);
    end
    in_valid = 1'b0;
    tick();
    chk("t2_empty", out_valid, 0);

    // stall consumer, push 6 into depth-4 FIFO
    out_ready = 1'b0;
    s_ct = "DEFGHI"; s_pt = "ABCDEF";
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1; in_ct = s_ct[j];
      chk("t3_rdy_fill", in_ready, 1);
      tick();
    end
    in_ct = s_ct[4];
    chk("t3_full", in_ready, 0);
    chk("t3_head", out_pt, "A");
    out_ready = 1'b1;
    #1;
    chk("t3_no_passthru", in_ready, 0);
    sent = 4; rcv = 0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      if (out_valid) begin
        chk("t3_order", out_pt, s_pt[rcv]);
        chk("t3_last", out_last, 0);
        rcv++;
      end
      in_valid = (sent < 6);
      if (sent < 6) in_ct = s_ct[sent];
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("t3_rcv", rcv, 6);
    chk("t3_sent", sent, 6);
    chk("t3_empty", out_valid, 0);

    // message "ab" under stall, then a second message
    out_ready = 1'b0;
    in_valid = 1'b1; in_ct = "d"; in_last = 1'b0;
    chk("t4_rdy0", in_ready, 1);
    tick();
    in_ct = "e"; in_last = 1'b1;
    chk("t4_rdy1", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_drain", in_ready, 0);
    tick();
    chk("t4_drain_hold", in_ready, 0);
    chk("t4_pt_a", out_pt, "a");
    out_ready = 1'b1;
    tick();
    chk("t4_drain_1left", in_ready, 0);
    chk("t4_pt_b", out_pt, "b");
    chk("t4_last_b", out_last, 1);
    tick();
    chk("t4_rdy_back", in_ready, 1);
    chk("t4_msg_count", msg_count, 2);
    chk("t4_empty", out_valid, 0);
    in_valid = 1'b1; in_ct = "f"; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t4_pt_c", out_pt, "c");
    chk("t4_last_c", out_last, 1);
    tick();
    chk("t4_msg_count2", msg_count, 3);
    chk("t4_rdy2", in_ready, 1);

    // key_load with a byte buffered is rejected
    out_ready = 1'b0;
    in_valid = 1'b1; in_ct = "x";
    tick();
    in_valid = 1'b0;
    key_load = 1'b1; key_in = 5'd5;
    tick();
    key_load = 1'b0;
    chk("t5_err_pulse", key_err, 1);
    in_valid = 1'b1; in_ct = "y";
    tick();
    in_valid = 1'b0;
    chk("t5_err_clear", key_err, 0);
    out_ready = 1'b1;
    chk("t5_pt_u", out_pt, "u");
    tick();
    chk("t5_key_kept", out_pt, "v");
    tick();
    chk("t5_empty", out_valid, 0);
    load_key(5'd5);
    chk("t5_accept", key_err, 0);
    in_valid = 1'b1; in_ct = "f";
    tick();
    in_valid = 1'b0;
    chk("t5_new_key", out_pt, "a");
    tick();
    // load coinciding with an accepted byte is rejected; byte still uses key 5
    key_load = 1'b1; key_in = 5'd0;
    in_valid = 1'b1; in_ct = "g";
    tick();
    key_load = 1'b0; in_valid = 1'b0;
    chk("t5_err_same_cycle", key_err, 1);
    chk("t5_pt_b", out_pt, "b");
    tick();

    // async reset with 3 bytes buffered
    out_ready = 1'b0;
    s_ct = "abc";
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ct = s_ct[i];
      tick();
    end
    in_valid = 1'b0;
    chk("t6_buffered", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_msg_count", msg_count, 0);
    chk("t6_key_set", key_set, 0);
    chk("t6_out_pt", out_pt, 0);
    chk("t6_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_ct = "q";
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_blocked", in_ready, 0);
      chk("t6_no_out", out_valid, 0);
    end
    in_valid = 1'b0;
    load_key(5'd0);
    chk("t6_rdy_after_key", in_ready, 1);
    chk("t6_still_empty", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
